// File: rtl/vector_serializer.sv
// Parallel-in, serial-out converter: takes a SIZE-element vector and streams it
// oldest-first (index SIZE-1 down to 0) over a valid/ready interface.
module vector_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]     in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic                                busy
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state;
  logic [SIZE-1:0][DATA_WIDTH-1:0] data_buf;
  logic [CW-1:0]                   cnt;
  logic                            load;
  logic                            beat;

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_data  = data_buf[SIZE-1];
  assign out_last  = (state == SHIFT) && (cnt == LAST_CNT);

  // Ready is combinational from out_ready so a new vector can load on the
  // final beat of the previous one without a bubble.
  assign in_ready = !flush && ((state == IDLE) || (out_last && out_ready));
  assign load     = in_valid && in_ready;
  assign beat     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_buf <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (load) begin
      data_buf <= in_data;
      cnt      <= '0;
      state    <= SHIFT;
    end else if (beat) begin
      if (out_last) begin
        // Buffer is left as-is; its contents are meaningless once idle.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        data_buf <= {data_buf[SIZE-2:0], {DATA_WIDTH{1'b0}}};
        cnt      <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vector_serializer.sv
// Bench for vector_serializer: queue-based stream model checked every cycle,
// directed scenarios with literal expectations, and a shift-register round trip.
module tb_vector_serializer;
  localparam int DW = 8;
  localparam int SIZE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [SIZE-1:0][DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [DW-1:0] out_data;

  int nvec = 0;
  int nfail = 0;
  bit chk_en = 1'b0;
  bit rt_en = 1'b0;

  logic [DW-1:0] q[$];
  logic [SIZE-1:0][DW-1:0] sent[$];
  logic [SIZE-1:0][DW-1:0] sr = '0;

  always #5 clk = ~clk;

  vector_serializer #(.DATA_WIDTH(DW), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: the in-flight vector is just a queue of elements still to send.
  always @(posedge clk) begin
    bit rdy;
    rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    if (rst_n && !flush && rt_en && out_valid && out_ready) begin
      sr = {sr[SIZE-2:0], out_data};
      if (out_last) begin
        if (sent.size() == 0) chk("rt_extra_vector", 1, 0);
        else chk("rt_vector", sr, sent.pop_front());
      end
    end
    if (!rst_n || flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        if (rt_en) sent.push_back(in_data);
        for (int i = SIZE - 1; i >= 0; i--) q.push_back(in_data[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", out_valid, q.size() != 0);
      chk("m_busy", busy, q.size() != 0);
      chk("m_last", out_last, q.size() == 1);
      chk("m_in_ready", in_ready, !flush && (q.size() == 0 || (q.size() == 1 && out_ready)));
      if (q.size() != 0) chk("m_data", out_data, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [SIZE-1:0][DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE-1:0][DW-1:0] va, vb;
    logic [DW-1:0] exp_a [SIZE];
    logic [DW-1:0] exp_b [SIZE];
    bit pat [7];
    int idx;
    bit acc;

    va = {8'h44, 8'h33, 8'h22, 8'h11};
    vb = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    exp_a = '{8'h44, 8'h33, 8'h22, 8'h11};
    exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Basic order
    out_ready = 1'b1;
    load(va);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("basic_data", out_data, exp_a[i]);
      chk("basic_last", out_last, i == SIZE - 1);
      tick();
    end
    @(negedge clk);
    chk("basic_end_valid", out_valid, 0);
    tick();

    // Back-to-back
    in_valid = 1'b1;
    in_data  = va;
    tick();
    in_data = vb;
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("b2b_data_a", out_data, exp_a[i]);
      chk("b2b_in_ready", in_ready, i == SIZE - 1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("b2b_valid_b", out_valid, 1);
      chk("b2b_data_b", out_data, exp_b[i]);
      tick();
    end
    @(negedge clk);
    chk("b2b_end_valid", out_valid, 0);
    tick();

    // Backpressure
    load(va);
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k];
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp_a[idx]);
      chk("bp_in_ready", in_ready, (idx == SIZE - 1) && pat[k]);
      if (pat[k]) idx++;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_end_valid", out_valid, 0);
    tick();

    // Flush on the second beat, with a competing load request
    load(va);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = vb;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready_after", in_ready, 1);
    tick();
    load(vb);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("flush_fresh_data", out_data, exp_b[i]);
      chk("flush_fresh_last", out_last, i == SIZE - 1);
      tick();
    end

    // Reset during the second beat
    load(va);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_in_ready", in_ready, 1);
    tick();

    // Round trip through a SIZE-deep shift register
    rt_en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      for (int e = 0; e < SIZE; e++) in_data[e] = DW'($urandom);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 64 && !acc; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = in_ready;
        tick();
      end
      if (!acc) chk("rt_accept_timeout", 0, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (SIZE + 2) tick();
    chk("rt_drained", sent.size(), 0);
    rt_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
